// File: rtl/regfile_arbiter_pkg.sv
// Shared widths, arbitration state and the micro-op record used by the
// two-requester regfile arbiter.
package regfile_arbiter_pkg;

    localparam int NUM_REGS = 8;
    localparam int SEL_W    = $clog2(NUM_REGS);
    localparam int DATA_W   = 16;

    typedef enum logic [1:0] {
        ARB_UNLOCKED,
        ARB_LOCKED0,
        ARB_LOCKED1
    } arb_state_e;

    // One micro-op as it is driven onto the regfile select/data lines.
    typedef struct packed {
        logic [SEL_W-1:0]  asel;
        logic [SEL_W-1:0]  bsel;
        logic [SEL_W-1:0]  dsel;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] rin;
    } rf_op_t;

    function automatic arb_state_e lock_state(input logic owner);
        return owner ? ARB_LOCKED1 : ARB_LOCKED0;
    endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// One requester port: micro-op handshake towards the arbiter and the
// registered response coming back.
interface regfile_arbiter_if;
    import regfile_arbiter_pkg::*;

    logic              valid;
    logic              ready;
    logic              lock;
    logic [SEL_W-1:0]  asel;
    logic [SEL_W-1:0]  bsel;
    logic [SEL_W-1:0]  dsel;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] rin;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_a;
    logic [DATA_W-1:0] rsp_b;

    modport master (
        output valid, lock, asel, bsel, dsel, din, rin,
        input  ready, rsp_valid, rsp_a, rsp_b
    );

    modport slave (
        input  valid, lock, asel, bsel, dsel, din, rin,
        output ready, rsp_valid, rsp_a, rsp_b
    );

endinterface

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin grant; a locked owner excludes the other requester
// entirely, and an unlocked tie goes to the priority pointer.
module rr_arb2
    import regfile_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    input  arb_state_e i_state,
    output logic [1:0] o_gnt
);

    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        o_gnt = 2'b00;
        case (i_state)
            ARB_LOCKED0: o_gnt[0] = i_req[0];
            ARB_LOCKED1: o_gnt[1] = i_req[1];
            default: begin
                if (i_req == 2'b11) begin
                    o_gnt[i_ptr] = 1'b1;
                end else begin
                    o_gnt = i_req;
                end
            end
        endcase
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one regfile between two requesters: grant in stage A, registered
// regfile drive in stage B, one-cycle response pulse in stage C.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    regfile_arbiter_if.slave  req0,
    regfile_arbiter_if.slave  req1,
    output logic [SEL_W-1:0]  RF_ASEL,
    output logic [SEL_W-1:0]  RF_BSEL,
    output logic [SEL_W-1:0]  RF_DSEL,
    output logic [DATA_W-1:0] RF_DIN,
    output logic [DATA_W-1:0] RF_RIN,
    input  logic [DATA_W-1:0] RF_ABUS,
    input  logic [DATA_W-1:0] RF_BBUS
);

    arb_state_e        r_state;
    logic              r_ptr;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic [1:0]        w_acc;
    logic [1:0]        w_lock;
    logic              w_owner;
    rf_op_t            w_op;
    rf_op_t            r_op;
    logic              r_b_valid;
    logic              r_b_owner;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_a [2];
    logic [DATA_W-1:0] r_rsp_b [2];

    assign w_req  = {req1.valid, req0.valid};
    assign w_lock = {req1.lock, req0.lock};

    rr_arb2 u_rr_arb2 (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .i_state (r_state),
        .o_gnt   (w_gnt)
    );

    // A grant always implies VALID, so the gated grant is both READY and accept.
    assign w_acc   = w_gnt & {2{~RST}};
    assign w_owner = w_acc[1];

    assign req0.ready = w_acc[0];
    assign req1.ready = w_acc[1];

    always_comb begin
        w_op = '0;
        if (w_acc[0]) begin
            w_op = '{asel: req0.asel, bsel: req0.bsel, dsel: req0.dsel,
                     din: req0.din, rin: req0.rin};
        end else if (w_acc[1]) begin
            w_op = '{asel: req1.asel, bsel: req1.bsel, dsel: req1.dsel,
                     din: req1.din, rin: req1.rin};
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            r_state <= ARB_UNLOCKED;
            r_ptr   <= 1'b0;
        end else if (|w_acc) begin
            r_ptr   <= ~w_owner;
            r_state <= w_lock[w_owner] ? lock_state(w_owner) : ARB_UNLOCKED;
        end
    end

    // Stage B drives the regfile; stage C captures its read buses for the owner.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_op        <= '0;
            r_b_valid   <= 1'b0;
            r_b_owner   <= 1'b0;
            r_rsp_valid <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_rsp_a[i] <= '0;
                r_rsp_b[i] <= '0;
            end
        end else begin
            r_op        <= w_op;
            r_b_valid   <= |w_acc;
            r_b_owner   <= w_owner;
            r_rsp_valid <= 2'b00;
            if (r_b_valid) begin
                r_rsp_valid[r_b_owner] <= 1'b1;
                r_rsp_a[r_b_owner]     <= RF_ABUS;
                r_rsp_b[r_b_owner]     <= RF_BBUS;
            end
        end
    end

    assign RF_ASEL = r_op.asel;
    assign RF_BSEL = r_op.bsel;
    assign RF_DSEL = r_op.dsel;
    assign RF_DIN  = r_op.din;
    assign RF_RIN  = r_op.rin;

    assign req0.rsp_valid = r_rsp_valid[0];
    assign req0.rsp_a     = r_rsp_a[0];
    assign req0.rsp_b     = r_rsp_b[0];
    assign req1.rsp_valid = r_rsp_valid[1];
    assign req1.rsp_a     = r_rsp_a[1];
    assign req1.rsp_b     = r_rsp_b[1];

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter with a behavioural REGFILE; directed vector table,
// hand sequences and random traffic against a transaction-level model.
module tb_regfile_arbiter;
    import regfile_arbiter_pkg::*;

    typedef struct packed {
        logic              valid;
        logic              lock;
        logic [SEL_W-1:0]  asel;
        logic [SEL_W-1:0]  bsel;
        logic [SEL_W-1:0]  dsel;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] rin;
    } req_t;

    typedef struct {
        req_t              r0;
        req_t              r1;
        logic [1:0]        rdy;
        logic [1:0]        rspv;
        logic [DATA_W-1:0] rsp_a;
    } vec_t;

    typedef struct {
        int                owner;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        int                due;
    } rsp_t;

    logic              clk;
    logic              rst;
    logic [SEL_W-1:0]  rf_asel, rf_bsel, rf_dsel;
    logic [DATA_W-1:0] rf_din, rf_rin, rf_abus, rf_bbus;
    logic [DATA_W-1:0] rf_mem [NUM_REGS];

    regfile_arbiter_if u_if0 ();
    regfile_arbiter_if u_if1 ();

    regfile_arbiter dut (
        .CLK     (clk),
        .RST     (rst),
        .req0    (u_if0),
        .req1    (u_if1),
        .RF_ASEL (rf_asel),
        .RF_BSEL (rf_bsel),
        .RF_DSEL (rf_dsel),
        .RF_DIN  (rf_din),
        .RF_RIN  (rf_rin),
        .RF_ABUS (rf_abus),
        .RF_BBUS (rf_bbus)
    );

    // Behavioural REGFILE: reg 0 reads DIN, write-through when a read select hits DSEL.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_mem[i] <= '0;
        end else if (rf_dsel != 0) begin
            rf_mem[rf_dsel] <= rf_rin;
        end
    end

    always_comb begin
        rf_abus = (rf_asel == 0) ? rf_din : (rf_asel == rf_dsel) ? rf_rin : rf_mem[rf_asel];
        rf_bbus = (rf_bsel == 0) ? rf_din : (rf_bsel == rf_dsel) ? rf_rin : rf_mem[rf_bsel];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int                n_cmp;
    int                n_fail;
    int                cyc;
    logic [DATA_W-1:0] m_mem [NUM_REGS];
    int                m_ptr;
    int                m_lock;
    rsp_t              m_q [$];
    logic [DATA_W-1:0] m_held_a [2];
    logic [DATA_W-1:0] m_held_b [2];
    logic [SEL_W-1:0]  m_rf_dsel;
    vec_t              tbl [$];
    req_t              idle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic req_t op(input bit v, input bit l, input int a, input int b, input int d,
                                input int din, input int rin);
        req_t r;
        r.valid = v;
        r.lock  = l;
        r.asel  = SEL_W'(a);
        r.bsel  = SEL_W'(b);
        r.dsel  = SEL_W'(d);
        r.din   = DATA_W'(din);
        r.rin   = DATA_W'(rin);
        return r;
    endfunction

    function automatic req_t rand_op();
        req_t r;
        r.valid = ($urandom_range(0, 3) != 0);
        r.lock  = ($urandom_range(0, 3) == 0);
        r.asel  = SEL_W'($urandom_range(0, NUM_REGS - 1));
        r.bsel  = SEL_W'($urandom_range(0, NUM_REGS - 1));
        r.dsel  = SEL_W'($urandom_range(0, NUM_REGS - 1));
        r.din   = DATA_W'($urandom);
        r.rin   = DATA_W'($urandom);
        return r;
    endfunction

    task automatic add(input req_t r0, input req_t r1, input logic [1:0] rdy,
                       input logic [1:0] rspv, input int a);
        vec_t v;
        v.r0    = r0;
        v.r1    = r1;
        v.rdy   = rdy;
        v.rspv  = rspv;
        v.rsp_a = DATA_W'(a);
        tbl.push_back(v);
    endtask

    task automatic drive(input req_t r0, input req_t r1);
        u_if0.valid = r0.valid; u_if0.lock = r0.lock;
        u_if0.asel  = r0.asel;  u_if0.bsel = r0.bsel; u_if0.dsel = r0.dsel;
        u_if0.din   = r0.din;   u_if0.rin  = r0.rin;
        u_if1.valid = r1.valid; u_if1.lock = r1.lock;
        u_if1.asel  = r1.asel;  u_if1.bsel = r1.bsel; u_if1.dsel = r1.dsel;
        u_if1.din   = r1.din;   u_if1.rin  = r1.rin;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_mem[i] = '0;
        m_ptr     = 0;
        m_lock    = -1;
        m_q.delete();
        m_held_a  = '{default: '0};
        m_held_b  = '{default: '0};
        m_rf_dsel = '0;
    endtask

    // Who the rules say wins this cycle, or -1 for nobody.
    function automatic int model_grant(input bit v0, input bit v1);
        if (m_lock == 0) return v0 ? 0 : -1;
        if (m_lock == 1) return v1 ? 1 : -1;
        if (v0 && v1)    return m_ptr;
        if (v0)          return 0;
        if (v1)          return 1;
        return -1;
    endfunction

    // A micro-op observes its own write; reg 0 always returns the op's DIN.
    function automatic logic [DATA_W-1:0] model_read(input logic [SEL_W-1:0] s,
                                                     input logic [DATA_W-1:0] din);
        return (s == 0) ? din : m_mem[s];
    endfunction

    task automatic check_outputs();
        logic [1:0] ev;
        ev = 2'b00;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            ev[m_q[0].owner]          = 1'b1;
            m_held_a[m_q[0].owner]    = m_q[0].a;
            m_held_b[m_q[0].owner]    = m_q[0].b;
            void'(m_q.pop_front());
        end
        check("rsp0_valid", u_if0.rsp_valid, ev[0]);
        check("rsp1_valid", u_if1.rsp_valid, ev[1]);
        check("rsp0_a", u_if0.rsp_a, m_held_a[0]);
        check("rsp0_b", u_if0.rsp_b, m_held_b[0]);
        check("rsp1_a", u_if1.rsp_a, m_held_a[1]);
        check("rsp1_b", u_if1.rsp_b, m_held_b[1]);
        check("rf_dsel", rf_dsel, m_rf_dsel);
    endtask

    task automatic cycle(input req_t r0, input req_t r1, input bit use_tbl,
                         input logic [1:0] t_rdy, input logic [1:0] t_rspv,
                         input logic [DATA_W-1:0] t_a);
        int   g;
        req_t r;
        rsp_t e;
        @(negedge clk);
        rst = 1'b0;
        drive(r0, r1);
        #1;
        g = model_grant(r0.valid, r1.valid);
        check("ready0", u_if0.ready, g == 0);
        check("ready1", u_if1.ready, g == 1);
        check_outputs();
        if (use_tbl) begin
            check("tbl_ready", {u_if1.ready, u_if0.ready}, t_rdy);
            check("tbl_rsp_valid", {u_if1.rsp_valid, u_if0.rsp_valid}, t_rspv);
            if (t_rspv[0]) check("tbl_rsp0_a", u_if0.rsp_a, t_a);
            if (t_rspv[1]) check("tbl_rsp1_a", u_if1.rsp_a, t_a);
        end
        m_rf_dsel = '0;
        if (g >= 0) begin
            r = (g == 1) ? r1 : r0;
            if (r.dsel != 0) m_mem[r.dsel] = r.rin;
            e.owner = g;
            e.a     = model_read(r.asel, r.din);
            e.b     = model_read(r.bsel, r.din);
            e.due   = cyc + 2;
            m_q.push_back(e);
            m_ptr     = 1 - g;
            m_lock    = r.lock ? g : -1;
            m_rf_dsel = r.dsel;
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        req_t a, b;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            a = rand_op(); a.valid = 1'b1;
            b = rand_op(); b.valid = 1'b1;
            drive(a, b);
            #1;
            check("rst_ready0", u_if0.ready, 1'b0);
            check("rst_ready1", u_if1.ready, 1'b0);
            if (i > 0) begin
                check("rst_rsp0_valid", u_if0.rsp_valid, 1'b0);
                check("rst_rsp1_valid", u_if1.rsp_valid, 1'b0);
                check("rst_rsp0_a", u_if0.rsp_a, 0);
                check("rst_rsp1_b", u_if1.rsp_b, 0);
                check("rst_rf_dsel", rf_dsel, 0);
            end
            cyc++;
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        rst    = 1'b1;
        idle   = '0;
        drive(idle, idle);
        do_reset(2);

        // Reads of regs 1..7 after reset, then write reg 3 and read it back.
        for (int k = 0; k < 7; k++) add(op(1, 0, k + 1, 0, 0, 0, 0), idle, 2'b01, (k >= 2) ? 2'b01 : 2'b00, 0);
        add(op(1, 0, 0, 0, 3, 0, 'h33), idle, 2'b01, 2'b01, 0);
        add(op(1, 0, 3, 0, 0, 0, 0),    idle, 2'b01, 2'b01, 0);
        add(idle, idle, 2'b00, 2'b01, 0);
        // Alternating grants with both requesters valid.
        add(idle, op(1, 0, 0, 0, 0, 'hF, 0), 2'b10, 2'b01, 'h33);
        add(op(1, 0, 3, 0, 0, 0, 0), op(1, 0, 0, 0, 0, 'hF, 0), 2'b01, 2'b00, 0);
        add(op(1, 0, 3, 0, 0, 0, 0), op(1, 0, 0, 0, 0, 'hF, 0), 2'b10, 2'b10, 'hF);
        add(op(1, 0, 3, 0, 0, 0, 0), op(1, 0, 0, 0, 0, 'hF, 0), 2'b01, 2'b01, 'h33);
        add(op(1, 0, 3, 0, 0, 0, 0), op(1, 0, 0, 0, 0, 'hF, 0), 2'b10, 2'b10, 'hF);
        // Requester 1 holds a lock across three ops, including an idle gap.
        add(op(1, 0, 4, 0, 0, 0, 0), op(1, 1, 0, 0, 4, 'hF, 'h44), 2'b01, 2'b01, 'h33);
        add(op(1, 0, 4, 0, 0, 0, 0), op(1, 1, 0, 0, 4, 'hF, 'h44), 2'b10, 2'b10, 'hF);
        add(op(1, 0, 4, 0, 0, 0, 0), idle,                          2'b00, 2'b01, 0);
        add(op(1, 0, 4, 0, 0, 0, 0), op(1, 1, 4, 0, 0, 0, 0),       2'b10, 2'b10, 'hF);
        add(op(1, 0, 4, 0, 0, 0, 0), op(1, 1, 4, 0, 5, 0, 'h55),    2'b10, 2'b00, 0);
        add(op(1, 0, 4, 0, 0, 0, 0), op(1, 0, 5, 0, 0, 0, 0),       2'b10, 2'b10, 'h44);
        add(op(1, 0, 5, 0, 0, 0, 0), op(1, 0, 4, 0, 0, 0, 0),       2'b01, 2'b10, 'h44);
        add(idle, idle, 2'b00, 2'b10, 'h55);
        add(idle, idle, 2'b00, 2'b01, 'h55);
        add(idle, idle, 2'b00, 2'b00, 0);

        foreach (tbl[i]) cycle(tbl[i].r0, tbl[i].r1, 1'b1, tbl[i].rdy, tbl[i].rspv, tbl[i].rsp_a);

        // Same-op write-through: both read buses see the value being written.
        cycle(op(1, 0, 5, 5, 5, 0, 'h15), idle, 1'b0, 2'b00, 2'b00, '0);
        cycle(idle, idle, 1'b0, 2'b00, 2'b00, '0);
        cycle(idle, idle, 1'b0, 2'b00, 2'b00, '0);
        check("bypass_valid", u_if0.rsp_valid, 1'b1);
        check("bypass_a", u_if0.rsp_a, 'h15);
        check("bypass_b", u_if0.rsp_b, 'h15);

        // Reset one cycle after a locking accept: no response, lock dropped, regs cleared.
        cycle(op(1, 1, 3, 0, 0, 0, 0), idle, 1'b0, 2'b00, 2'b00, '0);
        do_reset(1);
        cycle(idle, op(1, 0, 0, 0, 0, 'hF, 0), 1'b0, 2'b00, 2'b00, '0);
        check("postrst_no_rsp", u_if0.rsp_valid, 1'b0);
        check("postrst_unlocked", u_if1.ready, 1'b1);
        cycle(op(1, 0, 3, 3, 0, 0, 0), idle, 1'b0, 2'b00, 2'b00, '0);
        cycle(idle, idle, 1'b0, 2'b00, 2'b00, '0);
        cycle(idle, idle, 1'b0, 2'b00, 2'b00, '0);
        check("postrst_rd_valid", u_if0.rsp_valid, 1'b1);
        check("postrst_rd_a", u_if0.rsp_a, 0);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset(1);
            else cycle(rand_op(), rand_op(), 1'b0, 2'b00, 2'b00, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
